vm_sales_logger: RTL and testbench
==================================

Name: vm_sales_logger

Overview:
- Downstream consumer of the vending-machine core.
- Snoops the machine's item-price load stream and its 6-beat result burst (out_valid / out_consumer / out_sell_num).
- Accumulates lifetime per-item sales, returned-coin counts per denomination, transaction counts and revenue.
- Exposes the totals through a registered read port for the host/monitor.

Parameters:
- CNT_W, 16: width of every count accumulator; saturating.
- REV_W, 20: width of the revenue accumulator and of rd_data; saturating. Constraint: REV_W >= CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_item_valid  in  1  price-load strobe (same wire as the VM input).
- in_item_price  in  5  price of item 1..6, one per cycle while in_item_valid.
- out_valid  in  1  VM result-burst valid.
- out_consumer  in  4  beat0 = item id bought (0 = return only); beats1..5 = count of 50,20,10,5,1 coins returned.
- out_sell_num  in  6  beat k = units of item k+1 sold in this transaction.
- clr  in  1  synchronous clear of all accumulators; prices are kept.
- rd_en  in  1  read request.
- rd_addr  in  4  read address (map below).
- rd_data  out  REV_W  read data, zero-extended.
- rd_valid  out  1  pulses 1 cycle after rd_en.
- busy  out  1  high while a burst is being captured.
- err_burst  out  1  sticky flag: a burst was truncated.

Behaviour:
- Reset: all accumulators, prices, shadow registers, rd_data, rd_valid, busy and err_burst go to 0. State goes to IDLE.
- Price table:
  - Index counter runs 0..5 while in_item_valid is high; price[idx] <= in_item_price each cycle.
  - Counter returns to 0 whenever in_item_valid is low.
  - More than 6 valid cycles: extra beats are ignored until in_item_valid drops.
- FSM IDLE -> BURST:
  - Transition on out_valid=1, capturing beat 0 in that same cycle. busy=1 from the next cycle through the commit cycle.
  - In BURST, beat counter b = 1..5 captures one beat per cycle.
  - Every beat k: shadow_sold[k] <= out_sell_num; shadow_rev += out_sell_num * price[k]. Product is 11 bits; it is added using the price value registered before any same-cycle price write.
  - Beat 0 also latches item id. Beats 1..5 latch coin counts into shadow_coin[b-1].
- Commit:
  - Happens on the cycle beat 5 is captured, then FSM goes to IDLE.
  - All accumulators update atomically on that edge: sold[i] += shadow_sold[i]; coin[d] += shadow_coin[d]; revenue += shadow_rev.
  - id != 0: txn_cnt += 1. id == 0: rtn_cnt += 1.
  - All adds saturate at all-ones.
  - Reads never observe a partial burst.
- Truncation:
  - out_valid drops in BURST before beat 5: shadows are discarded, err_burst <= 1 (sticky until rst or clr), FSM goes to IDLE.
  - out_valid still high after beat 5: treated as beat 0 of a new burst.
- clr:
  - Zeroes the accumulators and err_burst next edge.
  - Same cycle as a commit: clr wins and the burst is discarded.
  - During BURST: FSM aborts to IDLE; remaining beats are ignored until out_valid goes low.
- Read port:
  - rd_en at cycle t gives rd_data/rd_valid at t+1. rd_data holds its value when rd_en=0.
  - Read in the same cycle as a commit returns the pre-commit value.
  - Map: 0-5 sold[item1..6]; 6-10 coin[50,20,10,5,1]; 11 txn_cnt; 12 rtn_cnt; 13 revenue; 14 {err_burst, busy}; 15 constant 0.

Decomposition:
- Package vm_log_pkg holds:
  - state enum {IDLE, BURST};
  - NUM_ITEMS=6, NUM_COIN=5;
  - address constants ADDR_SOLD0..ADDR_STATUS;
  - coin value constants 50/20/10/5/1, for bench revenue checking.
- Sub-module vm_log_sat_acc: a parameterised saturating accumulator with clear; instantiated per counter.

Test Plan:
- Load prices 10,20,5,15,25,30. Burst: id=2; coins 0,1,0,0,3; sell 0,2,0,0,0,0. Expected reads: addr1=2, addr7=1, addr10=3, addr11=1, addr13=40.
- Return-only burst: id=0, coins 2,0,0,1,0, sell all 0. Expected: rtn_cnt=1, txn_cnt unchanged, coin50=2, coin5=1, revenue unchanged.
- out_valid drops after beat 3. Expected: no accumulator changes, err_burst=1, addr14=2'b10. A following full burst commits normally.
- Preload sold[0]=65534, then burst with sell item1=5. Expected: sold[0]=65535 (saturated), other counters correct.
- Assert clr in the same cycle as beat 5. Expected: all reads 0, err_burst=0, prices retained; the next burst's revenue uses the old prices.
- rd_en on addr13 in the commit cycle returns the old revenue; rd_en on the next cycle returns the new revenue. rd_valid is a 1-cycle pulse each time.

Source files
------------

// File: rtl/vm_log_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vm_log_pkg : shared types and constants for the vending sales logger   |
// | Revision   : 1.0                                                       |
// +-----------------------------------------------------------------------+
package vm_log_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int NUM_ITEMS = 6;
  localparam int NUM_COIN  = 5;

  localparam logic [3:0] ADDR_SOLD0  = 4'd0;
  localparam logic [3:0] ADDR_COIN0  = 4'd6;
  localparam logic [3:0] ADDR_TXN    = 4'd11;
  localparam logic [3:0] ADDR_RTN    = 4'd12;
  localparam logic [3:0] ADDR_REV    = 4'd13;
  localparam logic [3:0] ADDR_STATUS = 4'd14;

  localparam int COIN_VAL_50 = 50;
  localparam int COIN_VAL_20 = 20;
  localparam int COIN_VAL_10 = 10;
  localparam int COIN_VAL_5  = 5;
  localparam int COIN_VAL_1  = 1;

endpackage
`default_nettype wire

// File: rtl/vm_log_sat_acc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vm_log_sat_acc : saturating accumulator with synchronous clear         |
// | Revision       : 1.0                                                   |
// +-----------------------------------------------------------------------+
module vm_log_sat_acc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [WIDTH-1:0] add_val,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc} + {1'b0, add_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vm_sales_logger.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vm_sales_logger : snoops VM price loads and result bursts, keeps totals|
// | Revision        : 1.0                                                  |
// +-----------------------------------------------------------------------+
module vm_sales_logger
  import vm_log_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_item_valid,
  input  logic [4:0]       in_item_price,
  input  logic             out_valid,
  input  logic [3:0]       out_consumer,
  input  logic [5:0]       out_sell_num,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [3:0]       rd_addr,
  output logic [REV_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             err_burst
);

  logic [4:0]       price [NUM_ITEMS];
  logic [2:0]       price_idx;
  state_t           state;
  logic [2:0]       beat;
  logic             drain;
  logic [3:0]       shadow_id;
  logic [5:0]       shadow_sold [NUM_ITEMS-1];
  logic [3:0]       shadow_coin [NUM_COIN-1];
  logic [REV_W-1:0] shadow_rev;

  logic [2:0]       cur_beat;
  logic [4:0]       cur_price;
  logic [10:0]      product;
  logic             commit;
  logic [CNT_W-1:0] sold [NUM_ITEMS];
  logic [CNT_W-1:0] coin [NUM_COIN];
  logic [CNT_W-1:0] txn_cnt;
  logic [CNT_W-1:0] rtn_cnt;
  logic [REV_W-1:0] revenue;
  logic [REV_W-1:0] rd_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      price_idx <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) price[i] <= '0;
    end else if (!in_item_valid) begin
      price_idx <= '0;
    end else if (price_idx < 3'(NUM_ITEMS)) begin
      for (int i = 0; i < NUM_ITEMS; i++)
        if (price_idx == 3'(i)) price[i] <= in_item_price;
      price_idx <= price_idx + 3'd1;
    end
  end

  // The product uses the price held before any same-cycle price write.
  assign cur_beat = (state == BURST) ? beat : 3'd0;
  always_comb begin
    cur_price = price[0];
    for (int i = 1; i < NUM_ITEMS; i++)
      if (cur_beat == 3'(i)) cur_price = price[i];
  end
  assign product = {5'b0, out_sell_num} * {6'b0, cur_price};
  assign commit  = (state == BURST) && out_valid && !clr && (beat == 3'd5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      drain      <= 1'b0;
      busy       <= 1'b0;
      err_burst  <= 1'b0;
      shadow_id  <= '0;
      shadow_rev <= '0;
      for (int i = 0; i < NUM_ITEMS-1; i++) shadow_sold[i] <= '0;
      for (int d = 0; d < NUM_COIN-1; d++)  shadow_coin[d] <= '0;
    end else begin
      if (clr) err_burst <= 1'b0;
      case (state)
        IDLE: begin
          if (out_valid && !drain && !clr) begin
            state          <= BURST;
            busy           <= 1'b1;
            beat           <= 3'd1;
            shadow_id      <= out_consumer;
            shadow_sold[0] <= out_sell_num;
            shadow_rev     <= REV_W'(product);
          end else if (clr && out_valid) begin
            drain <= 1'b1;
          end
        end
        BURST: begin
          if (clr) begin
            state <= IDLE;
            busy  <= 1'b0;
            drain <= out_valid;
          end else if (!out_valid) begin
            state     <= IDLE;
            busy      <= 1'b0;
            err_burst <= 1'b1;
          end else begin
            for (int i = 1; i < NUM_ITEMS-1; i++)
              if (beat == 3'(i)) shadow_sold[i] <= out_sell_num;
            for (int d = 0; d < NUM_COIN-1; d++)
              if (beat == 3'(d+1)) shadow_coin[d] <= out_consumer;
            shadow_rev <= shadow_rev + REV_W'(product);
            if (beat == 3'd5) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (!out_valid) drain <= 1'b0;
    end
  end

  // The final beat feeds the accumulators directly, bypassing the shadows.
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_sold
    logic [5:0] add;
    if (i == NUM_ITEMS-1) begin : g_last
      assign add = out_sell_num;
    end else begin : g_shadow
      assign add = shadow_sold[i];
    end
    vm_log_sat_acc #(.WIDTH(CNT_W)) u_acc (
      .clk(clk), .rst(rst), .clr(clr), .add_en(commit),
      .add_val(CNT_W'(add)), .acc(sold[i])
    );
  end

  for (genvar d = 0; d < NUM_COIN; d++) begin : g_coin
    logic [3:0] add;
    if (d == NUM_COIN-1) begin : g_last
      assign add = out_consumer;
    end else begin : g_shadow
      assign add = shadow_coin[d];
    end
    vm_log_sat_acc #(.WIDTH(CNT_W)) u_acc (
      .clk(clk), .rst(rst), .clr(clr), .add_en(commit),
      .add_val(CNT_W'(add)), .acc(coin[d])
    );
  end

  vm_log_sat_acc #(.WIDTH(CNT_W)) u_txn (
    .clk(clk), .rst(rst), .clr(clr), .add_en(commit && (shadow_id != 4'd0)),
    .add_val(CNT_W'(1'b1)), .acc(txn_cnt)
  );

  vm_log_sat_acc #(.WIDTH(CNT_W)) u_rtn (
    .clk(clk), .rst(rst), .clr(clr), .add_en(commit && (shadow_id == 4'd0)),
    .add_val(CNT_W'(1'b1)), .acc(rtn_cnt)
  );

  vm_log_sat_acc #(.WIDTH(REV_W)) u_rev (
    .clk(clk), .rst(rst), .clr(clr), .add_en(commit),
    .add_val(shadow_rev + REV_W'(product)), .acc(revenue)
  );

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (rd_addr == ADDR_SOLD0 + 4'(i)) rd_mux = REV_W'(sold[i]);
    for (int d = 0; d < NUM_COIN; d++)
      if (rd_addr == ADDR_COIN0 + 4'(d)) rd_mux = REV_W'(coin[d]);
    if (rd_addr == ADDR_TXN)    rd_mux = REV_W'(txn_cnt);
    if (rd_addr == ADDR_RTN)    rd_mux = REV_W'(rtn_cnt);
    if (rd_addr == ADDR_REV)    rd_mux = revenue;
    if (rd_addr == ADDR_STATUS) rd_mux = REV_W'({err_burst, busy});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vm_sales_logger.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_vm_sales_logger : scoreboard bench for the vending sales logger     |
// | Revision           : 1.0                                               |
// +-----------------------------------------------------------------------+
module tb_vm_sales_logger;
  import vm_log_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_item_valid;
  logic [4:0]  in_item_price;
  logic        out_valid;
  logic [3:0]  out_consumer;
  logic [5:0]  out_sell_num;
  logic        clr;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [19:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        err_burst;

  vm_sales_logger #(.CNT_W(16), .REV_W(20)) dut (
    .clk(clk), .rst(rst),
    .in_item_valid(in_item_valid), .in_item_price(in_item_price),
    .out_valid(out_valid), .out_consumer(out_consumer), .out_sell_num(out_sell_num),
    .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .err_burst(err_burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] sb_exp  [$];
  logic [3:0]  sb_addr [$];

  int m_sold [6];
  int m_coin [5];
  int m_txn, m_rtn, m_rev;
  int mprice [6];
  int bc [5];
  int bs [6];

  localparam int CNT_MAX = 65535;
  localparam int REV_MAX = 1048575;

  // Scoreboard: every read pushed by do_read is popped when rd_valid shows up.
  always @(negedge clk) begin
    logic [19:0] e;
    logic [3:0]  a;
    if (rd_valid) begin
      n_checks++;
      if (sb_exp.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=%0d, expected no read", rd_data);
      end else begin
        e = sb_exp.pop_front();
        a = sb_addr.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data addr=%0d: got %0d, expected %0d", a, rd_data, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a, input int exp);
    sb_exp.push_back(20'(exp));
    sb_addr.push_back(a);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en   = 1'b0;
  endtask

  task automatic set_coins(input int c0, input int c1, input int c2, input int c3, input int c4);
    bc[0] = c0; bc[1] = c1; bc[2] = c2; bc[3] = c3; bc[4] = c4;
  endtask

  task automatic set_sells(input int s0, input int s1, input int s2, input int s3,
                           input int s4, input int s5);
    bs[0] = s0; bs[1] = s1; bs[2] = s2; bs[3] = s3; bs[4] = s4; bs[5] = s5;
  endtask

  task automatic load_prices(input int p0, input int p1, input int p2, input int p3,
                             input int p4, input int p5, input int extra);
    int p [6];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3; p[4] = p4; p[5] = p5;
    for (int i = 0; i < 6 + extra; i++) begin
      in_item_valid = 1'b1;
      in_item_price = (i < 6) ? 5'(p[i]) : 5'd31;
      step();
    end
    in_item_valid = 1'b0;
    in_item_price = 5'd0;
    for (int i = 0; i < 6; i++) mprice[i] = p[i];
  endtask

  task automatic run_burst(input int id, input int nbeats, input bit clr_last, input bit rd_last);
    int rev_add;
    for (int k = 0; k < nbeats; k++) begin
      out_valid    = 1'b1;
      out_consumer = (k == 0) ? 4'(id) : 4'(bc[k-1]);
      out_sell_num = 6'(bs[k]);
      if (k == 5 && clr_last) clr = 1'b1;
      if (k == 5 && rd_last) begin
        sb_exp.push_back(20'(m_rev));
        sb_addr.push_back(ADDR_REV);
        rd_en   = 1'b1;
        rd_addr = ADDR_REV;
      end
      step();
      clr   = 1'b0;
      rd_en = 1'b0;
      if (k == 0) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_in_burst: got %b, expected 1", busy);
        end
      end
    end
    out_valid    = 1'b0;
    out_consumer = 4'd0;
    out_sell_num = 6'd0;
    if (nbeats == 6) begin
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_after_burst: got %b, expected 0", busy);
      end
    end
    if (clr_last) begin
      for (int i = 0; i < 6; i++) m_sold[i] = 0;
      for (int d = 0; d < 5; d++) m_coin[d] = 0;
      m_txn = 0; m_rtn = 0; m_rev = 0;
    end else if (nbeats == 6) begin
      rev_add = 0;
      for (int i = 0; i < 6; i++) begin
        m_sold[i] = sat(m_sold[i] + bs[i], CNT_MAX);
        rev_add  += bs[i] * mprice[i];
      end
      for (int d = 0; d < 5; d++) m_coin[d] = sat(m_coin[d] + bc[d], CNT_MAX);
      if (id != 0) m_txn = sat(m_txn + 1, CNT_MAX);
      else         m_rtn = sat(m_rtn + 1, CNT_MAX);
      m_rev = sat(m_rev + rev_add, REV_MAX);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_item_valid = 1'b0; in_item_price = '0; out_valid = 1'b0;
    out_consumer = '0; out_sell_num = '0; clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < 6; i++) begin m_sold[i] = 0; mprice[i] = 0; end
    for (int d = 0; d < 5; d++) m_coin[d] = 0;
    m_txn = 0; m_rtn = 0; m_rev = 0;
    repeat (3) step();
    n_checks += 4;
    if (rd_data !== 20'd0)  begin n_fail++; $display("FAIL reset_rd_data: got %0d, expected 0", rd_data); end
    if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid: got %b, expected 0", rd_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (err_burst !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err_burst); end
    rst = 1'b0;
    step();
    for (int a = 0; a < 16; a++) do_read(4'(a), 0);
  endtask

  task automatic test_purchase();
    load_prices(10, 20, 5, 15, 25, 30, 2);
    set_coins(0, 1, 0, 0, 3);
    set_sells(0, 2, 0, 0, 0, 0);
    run_burst(2, 6, 1'b0, 1'b0);
    step();
    do_read(4'd1, 2);
    do_read(4'd7, 1);
    do_read(4'd10, 3);
    do_read(4'd11, 1);
    do_read(4'd13, 40);
  endtask

  task automatic test_return();
    set_coins(2, 0, 0, 1, 0);
    set_sells(0, 0, 0, 0, 0, 0);
    run_burst(0, 6, 1'b0, 1'b0);
    step();
    do_read(4'd12, 1);
    do_read(4'd11, 1);
    do_read(4'd6, 2);
    do_read(4'd9, 1);
    do_read(4'd13, 40);
  endtask

  task automatic test_truncate();
    set_coins(1, 1, 1, 1, 1);
    set_sells(1, 1, 1, 1, 1, 1);
    run_burst(7, 4, 1'b0, 1'b0);
    step();
    n_checks++;
    if (err_burst !== 1'b1) begin n_fail++; $display("FAIL trunc_err: got %b, expected 1", err_burst); end
    do_read(4'd0, 0);
    do_read(4'd1, 2);
    do_read(4'd6, 2);
    do_read(4'd11, 1);
    do_read(4'd12, 1);
    do_read(4'd13, 40);
    do_read(ADDR_STATUS, 2);
    set_coins(0, 0, 0, 0, 0);
    set_sells(0, 0, 1, 0, 0, 0);
    run_burst(3, 6, 1'b0, 1'b0);
    step();
    do_read(4'd2, 1);
    do_read(4'd11, 2);
    do_read(4'd13, 45);
    do_read(ADDR_STATUS, 2);
  endtask

  task automatic test_read_commit();
    set_coins(0, 0, 0, 0, 0);
    set_sells(1, 0, 0, 0, 0, 0);
    run_burst(1, 6, 1'b0, 1'b1);
    do_read(ADDR_REV, 55);
    n_checks++;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid_pulse_hi: got %b, expected 1", rd_valid); end
    step();
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse_lo: got %b, expected 0", rd_valid); end
  endtask

  task automatic test_clr_commit();
    set_coins(1, 1, 1, 1, 1);
    set_sells(0, 0, 0, 1, 1, 1);
    run_burst(4, 6, 1'b1, 1'b0);
    step();
    n_checks++;
    if (err_burst !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b, expected 0", err_burst); end
    for (int a = 0; a < 16; a++) do_read(4'(a), 0);
    set_coins(0, 0, 0, 0, 0);
    set_sells(1, 1, 1, 1, 1, 1);
    run_burst(5, 6, 1'b0, 1'b0);
    step();
    do_read(ADDR_REV, 105);
    do_read(4'd0, 1);
    do_read(4'd5, 1);
    do_read(ADDR_TXN, 1);
    do_read(ADDR_RTN, 0);
  endtask

  task automatic test_saturate();
    int r;
    set_coins(0, 0, 0, 0, 0);
    set_sells(63, 0, 0, 0, 0, 0);
    while (m_sold[0] + 63 <= 65534) run_burst(1, 6, 1'b0, 1'b0);
    r = 65534 - m_sold[0];
    if (r > 0) begin
      set_sells(r, 0, 0, 0, 0, 0);
      run_burst(1, 6, 1'b0, 1'b0);
    end
    step();
    do_read(4'd0, 65534);
    set_coins(0, 0, 0, 0, 2);
    set_sells(5, 0, 0, 0, 0, 1);
    run_burst(1, 6, 1'b0, 1'b0);
    step();
    do_read(4'd0, 65535);
    do_read(4'd5, m_sold[5]);
    do_read(4'd10, m_coin[4]);
    do_read(ADDR_TXN, m_txn);
    do_read(ADDR_REV, m_rev);
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_return();
    test_truncate();
    test_read_commit();
    test_clr_commit();
    test_saturate();
    repeat (2) step();
    n_checks++;
    if (sb_exp.size() != 0) begin
      n_fail++;
      $display("FAIL rd_missing: got %0d reads outstanding, expected 0", sb_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
